// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC/latch lock and flush generation for load-use,
// EX redirects and data-memory wait states, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rr_rs1_i,
    input  logic [4:0]       rr_rs2_i,
    input  logic             rr_use_rs1_i,
    input  logic             rr_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_lock_o,
    output logic             if_id_lock_o,
    output logic             id_rr_lock_o,
    output logic             rr_ex_lock_o,
    output logic             if_id_flush_o,
    output logic             id_rr_flush_o,
    output logic             rr_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             lu_active_o
);

    typedef enum logic {
        RUN,
        LU_STALL
    } state_e;

    localparam logic [2:0] LuReload = 3'(LU_STALL_CYC - 1);

    state_e           state_q, state_d;
    logic [2:0]       lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_hit;
    logic             flush_inc;

    assign lu_hit = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((rr_use_rs1_i && (rr_rs1_i == ex_rd_i)) ||
                     (rr_use_rs2_i && (rr_rs2_i == ex_rd_i)));

    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        pc_lock_o     = 1'b0;
        if_id_lock_o  = 1'b0;
        id_rr_lock_o  = 1'b0;
        rr_ex_lock_o  = 1'b0;
        if_id_flush_o = 1'b0;
        id_rr_flush_o = 1'b0;
        rr_ex_flush_o = 1'b0;
        flush_inc     = 1'b0;

        if (mem_busy_i) begin
            // Full freeze: FSM and bubble counter hold their values.
            pc_lock_o    = 1'b1;
            if_id_lock_o = 1'b1;
            id_rr_lock_o = 1'b1;
            rr_ex_lock_o = 1'b1;
        end else if (ex_redirect_i) begin
            // A redirect squashes the younger dependent, so any pending stall is dropped.
            if_id_flush_o = 1'b1;
            id_rr_flush_o = 1'b1;
            rr_ex_flush_o = 1'b1;
            flush_inc     = 1'b1;
            state_d       = RUN;
            lu_cnt_d      = 3'd0;
        end else if (state_q == LU_STALL || lu_hit) begin
            pc_lock_o     = 1'b1;
            if_id_lock_o  = 1'b1;
            id_rr_lock_o  = 1'b1;
            rr_ex_flush_o = 1'b1;
            if (state_q == LU_STALL) begin
                lu_cnt_d = lu_cnt_q - 3'd1;
                if (lu_cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end else if (LU_STALL_CYC > 1) begin
                state_d  = LU_STALL;
                lu_cnt_d = LuReload;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_lock_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            lu_cnt_q    <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign lu_active_o = (state_q == LU_STALL);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with a single-cycle
// load-use stall and one with a three-cycle stall share the same stimulus.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  rr_rs1_i, rr_rs2_i, ex_rd_i;
    logic        rr_use_rs1_i, rr_use_rs2_i, ex_memread_i, ex_redirect_i, mem_busy_i;

    logic        p1_pc_lock, p1_if_id_lock, p1_id_rr_lock, p1_rr_ex_lock;
    logic        p1_if_id_flush, p1_id_rr_flush, p1_rr_ex_flush, p1_lu_active;
    logic [15:0] p1_stall_cnt, p1_flush_cnt;
    logic        p3_pc_lock, p3_if_id_lock, p3_id_rr_lock, p3_rr_ex_lock;
    logic        p3_if_id_flush, p3_id_rr_flush, p3_rr_ex_flush, p3_lu_active;
    logic [15:0] p3_stall_cnt, p3_flush_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.LU_STALL_CYC(1), .CNT_W(16)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rr_rs1_i(rr_rs1_i), .rr_rs2_i(rr_rs2_i),
        .rr_use_rs1_i(rr_use_rs1_i), .rr_use_rs2_i(rr_use_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
        .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
        .pc_lock_o(p1_pc_lock), .if_id_lock_o(p1_if_id_lock),
        .id_rr_lock_o(p1_id_rr_lock), .rr_ex_lock_o(p1_rr_ex_lock),
        .if_id_flush_o(p1_if_id_flush), .id_rr_flush_o(p1_id_rr_flush),
        .rr_ex_flush_o(p1_rr_ex_flush),
        .stall_cnt_o(p1_stall_cnt), .flush_cnt_o(p1_flush_cnt),
        .lu_active_o(p1_lu_active)
    );

    pipe_hazard_ctrl #(.LU_STALL_CYC(3), .CNT_W(16)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rr_rs1_i(rr_rs1_i), .rr_rs2_i(rr_rs2_i),
        .rr_use_rs1_i(rr_use_rs1_i), .rr_use_rs2_i(rr_use_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
        .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
        .pc_lock_o(p3_pc_lock), .if_id_lock_o(p3_if_id_lock),
        .id_rr_lock_o(p3_id_rr_lock), .rr_ex_lock_o(p3_rr_ex_lock),
        .if_id_flush_o(p3_if_id_flush), .id_rr_flush_o(p3_id_rr_flush),
        .rr_ex_flush_o(p3_rr_ex_flush),
        .stall_cnt_o(p3_stall_cnt), .flush_cnt_o(p3_flush_cnt),
        .lu_active_o(p3_lu_active)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic redir, input logic busy);
        rr_rs1_i      = rs1;
        rr_rs2_i      = rs2;
        rr_use_rs1_i  = u1;
        rr_use_rs2_i  = u2;
        ex_rd_i       = rd;
        ex_memread_i  = mr;
        ex_redirect_i = redir;
        mem_busy_i    = busy;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Inputs change at posedge+1 and are checked at posedge+2.
    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        #3;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic chk_lu_outputs(input string tag, input logic pc, input logic ifl,
                                  input logic idl, input logic rxl, input logic rxf);
        check({tag, ".pc_lock"}, p3_pc_lock, 32'(pc));
        check({tag, ".if_id_lock"}, p3_if_id_lock, 32'(ifl));
        check({tag, ".id_rr_lock"}, p3_id_rr_lock, 32'(idl));
        check({tag, ".rr_ex_lock"}, p3_rr_ex_lock, 32'(rxl));
        check({tag, ".rr_ex_flush"}, p3_rr_ex_flush, 32'(rxf));
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        #12;
        check("rst.pc_lock", p3_pc_lock, 0);
        check("rst.flushes", {p3_if_id_flush, p3_id_rr_flush, p3_rr_ex_flush}, 0);
        check("rst.stall_cnt", p3_stall_cnt, 0);
        check("rst.flush_cnt", p1_flush_cnt, 0);
        check("rst.lu_active", p3_lu_active, 0);

        // Load-use on rs2, single-cycle stall instance.
        do_reset();
        drive(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("lu1.pc_lock", p1_pc_lock, 1);
        check("lu1.if_id_lock", p1_if_id_lock, 1);
        check("lu1.id_rr_lock", p1_id_rr_lock, 1);
        check("lu1.rr_ex_lock", p1_rr_ex_lock, 0);
        check("lu1.rr_ex_flush", p1_rr_ex_flush, 1);
        check("lu1.if_id_flush", p1_if_id_flush, 0);
        step();
        idle();
        check("lu1.after.pc_lock", p1_pc_lock, 0);
        check("lu1.after.rr_ex_flush", p1_rr_ex_flush, 0);
        check("lu1.after.lu_active", p1_lu_active, 0);
        check("lu1.stall_cnt", p1_stall_cnt, 1);

        // x0 destination and unused operand never stall.
        do_reset();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        check("x0.p1.pc_lock", p1_pc_lock, 0);
        check("x0.p3.pc_lock", p3_pc_lock, 0);
        drive(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("unused.pc_lock", p3_pc_lock, 0);
        check("unused.rr_ex_flush", p3_rr_ex_flush, 0);
        step();
        idle();
        check("nohaz.stall_cnt", p3_stall_cnt, 0);

        // Three-cycle load-use stall on rs1.
        do_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        chk_lu_outputs("lu3.c0", 1, 1, 1, 0, 1);
        check("lu3.c0.lu_active", p3_lu_active, 0);
        step();
        idle();
        chk_lu_outputs("lu3.c1", 1, 1, 1, 0, 1);
        check("lu3.c1.lu_active", p3_lu_active, 1);
        check("lu3.c1.stall_cnt", p3_stall_cnt, 1);
        check("lu3.c1.p1.pc_lock", p1_pc_lock, 0);
        step();
        check("lu3.c2.lu_active", p3_lu_active, 1);
        check("lu3.c2.pc_lock", p3_pc_lock, 1);
        step();
        check("lu3.c3.lu_active", p3_lu_active, 0);
        check("lu3.c3.pc_lock", p3_pc_lock, 0);
        check("lu3.stall_cnt", p3_stall_cnt, 3);

        // Redirect wins over a simultaneous load-use hit.
        do_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        chk_lu_outputs("redir", 0, 0, 0, 0, 1);
        check("redir.if_id_flush", p3_if_id_flush, 1);
        check("redir.id_rr_flush", p3_id_rr_flush, 1);
        step();
        idle();
        check("redir.after.if_id_flush", p3_if_id_flush, 0);
        check("redir.lu_active", p3_lu_active, 0);
        check("redir.flush_cnt", p3_flush_cnt, 1);
        check("redir.p1.flush_cnt", p1_flush_cnt, 1);
        check("redir.stall_cnt", p3_stall_cnt, 0);

        // mem_busy freezes an LU_STALL for 4 cycles; a masked redirect is not counted.
        do_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk_lu_outputs("busy", 1, 1, 1, 1, 0);
        check("busy.if_id_flush", p3_if_id_flush, 0);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("busy.redir.if_id_flush", p3_if_id_flush, 0);
        check("busy.redir.rr_ex_lock", p3_rr_ex_lock, 1);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("busy.lu_active", p3_lu_active, 1);
        step();
        idle();
        check("busy.done.stall_cnt", p3_stall_cnt, 5);
        check("busy.done.flush_cnt", p3_flush_cnt, 0);
        check("busy.resume.lu_active", p3_lu_active, 1);
        chk_lu_outputs("busy.resume", 1, 1, 1, 0, 1);
        step();
        check("busy.resume2.lu_active", p3_lu_active, 1);
        step();
        check("busy.end.lu_active", p3_lu_active, 0);
        check("busy.end.pc_lock", p3_pc_lock, 0);
        check("busy.stall_cnt", p3_stall_cnt, 7);

        // Redirect inside LU_STALL returns to RUN immediately.
        do_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk_lu_outputs("lsredir", 0, 0, 0, 0, 1);
        check("lsredir.if_id_flush", p3_if_id_flush, 1);
        step();
        idle();
        check("lsredir.lu_active", p3_lu_active, 0);
        check("lsredir.pc_lock", p3_pc_lock, 0);
        check("lsredir.flush_cnt", p3_flush_cnt, 1);
        check("lsredir.stall_cnt", p3_stall_cnt, 1);

        // Asynchronous reset in the middle of LU_STALL.
        do_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("midrst.pre.lu_active", p3_lu_active, 1);
        idle();
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst.lu_active", p3_lu_active, 0);
        check("midrst.pc_lock", p3_pc_lock, 0);
        check("midrst.stall_cnt", p3_stall_cnt, 0);
        check("midrst.flush_cnt", p3_flush_cnt, 0);
        rst_ni = 1'b1;

        // Stall counter saturation at 2^16-1.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (65534) @(posedge clk_i);
        #1;
        check("sat.pre", p3_stall_cnt, 65534);
        repeat (3) @(posedge clk_i);
        #1;
        check("sat.p3", p3_stall_cnt, 65535);
        check("sat.p1", p1_stall_cnt, 65535);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
